uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
- Parametrised UART serial transmitter; successor to the fixed 8N1 transmitter.
- Adds configurable data width, parity and stop-bit count.
- Adds an internal transmit FIFO so producers can burst several words without waiting on each frame.
- Sits between a memory-mapped/CPU-side producer (valid/ready) and the board serial line.

Parameters:
- ClockFreq, 50_000_000: input clock frequency in Hz.
- BaudRate, 115_200: line rate. SymbolEdgeTime = ClockFreq/BaudRate cycles per bit (integer divide).
- DataWidth, 8: data bits per frame. Legal range 5..9.
- ParityMode, 0: 0 = none, 1 = odd, 2 = even.
- StopBits, 1: number of stop bits. Legal values 1 or 2.
- FifoDepth, 4: transmit FIFO entries. Power of 2, at least 2.

Ports:
- Clock  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- DataIn  in  DataWidth  word to transmit, sent LSB first.
- DataInValid  in  1  producer offers DataIn.
- DataInReady  out  1  FIFO can accept a word. High iff FifoCount < FifoDepth.
- SOut  out  1  serial line; idle high.
- Busy  out  1  high while a frame is on the line (start bit through last stop bit).
- FifoCount  out  log2(FifoDepth)+1  number of words queued, excluding the frame in flight.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; it has priority over all other activity.
- Reset values: SOut=1, Busy=0, FifoCount=0, DataInReady=1, FSM=IDLE, baud counter=0.
- Push: occurs on any edge where DataInValid && DataInReady. DataIn is stored at the write pointer; FifoCount increments that edge unless a pop happens on the same edge.
- Full FIFO: DataInReady=0; DataInValid is ignored and no data is lost or overwritten. DataInReady depends only on registered state, with no combinational path from DataInValid.
- Pop: occurs on an edge where the FSM is IDLE (or finishing its last stop symbol) and FifoCount>0.
  - The popped word loads the frame shift register.
  - The FSM enters START and the baud counter clears.
- Simultaneous push and pop on one edge: FifoCount unchanged and both pointers advance. This applies in the full state too, but only the pop is allowed there, since ready was low.
- FSM states:
  - IDLE: SOut=1, Busy=0.
  - START: SOut=0.
  - DATA: SOut = current bit, LSB first, for DataWidth symbols.
  - PARITY: only when ParityMode != 0. Odd parity sends the XOR of data bits, inverted; even parity sends the XOR of data bits.
  - STOP: SOut=1 for StopBits symbols.
- Symbol timing:
  - Each symbol lasts exactly SymbolEdgeTime cycles.
  - The baud counter counts 0..SymbolEdgeTime-1 and wraps.
  - State/bit advance happens on the edge where counter == SymbolEdgeTime-1.
- Latency: a word pushed at edge E0 into an empty FIFO with the FSM IDLE is popped at E1. SOut and Busy go low/high respectively after E1.
- Back-to-back frames: if FifoCount>0 at the terminal edge of the last stop symbol, the next START begins on that same edge. There is no idle gap and Busy stays high.
- Frame length: 1 + DataWidth + (ParityMode!=0) + StopBits symbols.
- Reset mid-frame: SOut=1 the cycle after the reset edge, the FIFO is flushed, and the partial frame is abandoned.
- Illegal parameters (DataWidth outside 5..9, ParityMode 3, StopBits not 1/2, FifoDepth not a power of 2): rejected by an elaboration-time error.

Test Plan:
- Idle/reset: ClockFreq=1000, BaudRate=100 (10 cycles/bit). Assert Reset 3 cycles -> SOut=1, Busy=0, DataInReady=1, FifoCount=0.
- 8N1: push 8'hA5 -> SOut low after E1 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles. Busy high 100 cycles.
- 7O2 (DataWidth=7, ParityMode=1, StopBits=2): push 7'h41 -> data 1,0,0,0,0,0,1, parity 1, two stop symbols. Frame is 110 cycles.
- Burst/full: FifoDepth=4, hold DataInValid with 6 words -> 5 accepted (1 in flight + 4 queued). DataInReady drops and FifoCount=4. All 6 frames go out back-to-back with no idle cycle between stop and start, and in order.
- Simultaneous push/pop: FIFO full, keep DataInValid high -> on the pop edge DataInReady rises next cycle. The word is accepted and FifoCount returns to 4 with no dropped or duplicated word.
- Reset mid-frame: assert Reset during the DATA bit 3 of 8'hFF with 2 words queued -> SOut=1 next cycle, FifoCount=0, no further frames transmitted.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (5..9 data bits, none/odd/even parity, 1-2 stops) fed by a small FIFO.
// A word pushed into an empty FIFO starts its frame one edge later; ready drops only when the FIFO is full.

module uart_tx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [Width-1:0]         wr_dat,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic                     rd_en,
    output logic [Width-1:0]         rd_dat,
    output logic [$clog2(Depth):0]   count
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push;
    logic             pop;

    // Ready is a function of the registered count only.
    assign wr_rdy = count < (AW+1)'(Depth);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_en && (count != '0);
    assign rd_dat = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module uart_tx_param #(
    parameter int ClockFreq  = 50_000_000,
    parameter int BaudRate   = 115_200,
    parameter int DataWidth  = 8,
    parameter int ParityMode = 0,
    parameter int StopBits   = 1,
    parameter int FifoDepth  = 4
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [DataWidth-1:0]        DataIn,
    input  logic                        DataInValid,
    output logic                        DataInReady,
    output logic                        SOut,
    output logic                        Busy,
    output logic [$clog2(FifoDepth):0]  FifoCount
);
    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int CntW = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
    localparam int BitW = $clog2(DataWidth);

    if (DataWidth < 5 || DataWidth > 9) begin : g_bad_width
        $error("uart_tx_param: DataWidth must be in 5..9");
    end
    if (ParityMode < 0 || ParityMode > 2) begin : g_bad_parity
        $error("uart_tx_param: ParityMode must be 0, 1 or 2");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
        $error("uart_tx_param: StopBits must be 1 or 2");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FifoDepth must be a power of 2, at least 2");
    end
    if (SymbolEdgeTime < 1) begin : g_bad_baud
        $error("uart_tx_param: BaudRate must not exceed ClockFreq");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [CntW-1:0]        baud_cnt;
    logic [BitW-1:0]        bit_idx;
    logic                   stop_idx;
    logic [DataWidth-1:0]   shift;
    logic                   par_bit;
    logic [DataWidth-1:0]   fifo_dat;
    logic                   tick;
    logic                   last_stop;
    logic                   pop;

    assign tick      = baud_cnt == CntW'(SymbolEdgeTime - 1);
    assign last_stop = (state == STOP) && tick && (stop_idx == 1'(StopBits - 1));
    // Popping on the final stop edge gives back-to-back frames with no idle cycle.
    assign pop       = ((state == IDLE) || last_stop) && (FifoCount != '0);

    uart_tx_fifo #(
        .Width (DataWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk    (Clock),
        .rst    (Reset),
        .wr_dat (DataIn),
        .wr_vld (DataInValid),
        .wr_rdy (DataInReady),
        .rd_en  (pop),
        .rd_dat (fifo_dat),
        .count  (FifoCount)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            SOut     <= 1'b1;
            Busy     <= 1'b0;
        end else if (pop) begin
            state    <= START;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= fifo_dat;
            par_bit  <= (^fifo_dat) ^ (ParityMode == 1);
            SOut     <= 1'b0;
            Busy     <= 1'b1;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            SOut     <= 1'b1;
            Busy     <= 1'b0;
        end else begin
            baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            if (tick) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_idx <= '0;
                        SOut    <= shift[0];
                    end
                    DATA: begin
                        if (bit_idx == BitW'(DataWidth - 1)) begin
                            if (ParityMode != 0) begin
                                state <= PARITY;
                                SOut  <= par_bit;
                            end else begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                                SOut     <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            SOut    <= shift[1];
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        SOut     <= 1'b1;
                    end
                    STOP: begin
                        if (last_stop) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                            SOut  <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        SOut  <= 1'b1;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
